// File: rtl/uart_mmio_pkg.sv
// Shared types and constants for the UART-to-MMIO command bridge.
package uart_mmio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPC,
        ADDR,
        DATA,
        BUS,
        RESP
    } state_t;

    localparam logic [7:0] OPC_WR  = 8'h57;
    localparam logic [7:0] OPC_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    localparam int unsigned ADDR_BYTES = 3;
    localparam int unsigned DATA_BYTES = 4;
    localparam int unsigned BCNT_W     = 3;

endpackage

// File: rtl/uart_mmio_timeout.sv
// Inter-byte timeout counter: counts enabled cycles, expires on the TIMEOUT_CYC-th one.
module uart_mmio_timeout #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned LAST  = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    logic [CNT_W-1:0] r_cnt;

    // A zero TIMEOUT_CYC never expires
    assign o_expire_c = (TIMEOUT_CYC != 0) && i_en && (r_cnt == CNT_W'(LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr || o_expire_c) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Byte-stream command interpreter: rx FIFO frames in, MMIO bus cycles out, replies to tx FIFO.
module uart_mmio_bridge
    import uart_mmio_pkg::*;
#(
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic              bus_cs,
    output logic              bus_read,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wr_data,
    input  logic [31:0]       bus_rd_data,
    output logic              busy,
    output logic              frame_err
);

    state_t              r_state,    w_state;
    logic                r_is_wr,    w_is_wr;
    logic [BCNT_W-1:0]   r_cnt,      w_cnt;
    logic [ADDR_W-1:0]   r_addr,     w_addr;
    logic [31:0]         r_wdata,    w_wdata;
    logic [31:0]         r_resp,     w_resp;
    logic [BCNT_W-1:0]   r_resp_cnt, w_resp_cnt;
    logic                w_tmo_en;
    logic                w_expire;

    assign w_tmo_en    = ((r_state == ADDR) || (r_state == DATA)) && rx_empty;
    assign bus_addr    = r_addr;
    assign bus_wr_data = r_wdata;
    assign w_data      = r_resp[31:24];
    assign busy        = (r_state != IDLE);

    uart_mmio_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (!w_tmo_en),
        .i_en       (w_tmo_en),
        .o_expire_c (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_is_wr    <= 1'b0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_resp     <= '0;
            r_resp_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_is_wr    <= w_is_wr;
            r_cnt      <= w_cnt;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_resp     <= w_resp;
            r_resp_cnt <= w_resp_cnt;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_is_wr    = r_is_wr;
        w_cnt      = r_cnt;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_resp     = r_resp;
        w_resp_cnt = r_resp_cnt;
        rd_uart    = 1'b0;
        wr_uart    = 1'b0;
        bus_cs     = 1'b0;
        bus_read   = 1'b0;
        bus_write  = 1'b0;
        frame_err  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!rx_empty) w_state = OPC;
            end
            OPC: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    if ((r_data == OPC_WR) || (r_data == OPC_RD)) begin
                        w_is_wr = (r_data == OPC_WR);
                        w_cnt   = '0;
                        w_state = ADDR;
                    end else begin
                        frame_err  = 1'b1;
                        w_resp     = {RSP_ERR, 24'h0};
                        w_resp_cnt = BCNT_W'(1);
                        w_state    = RESP;
                    end
                end
            end
            ADDR: begin
                if (w_expire) begin
                    frame_err = 1'b1;
                    w_state   = IDLE;
                end else if (!rx_empty) begin
                    rd_uart = 1'b1;
                    w_addr  = ADDR_W'({r_addr, r_data});
                    if (r_cnt == BCNT_W'(ADDR_BYTES - 1)) begin
                        w_cnt   = '0;
                        w_state = r_is_wr ? DATA : BUS;
                    end else begin
                        w_cnt = r_cnt + BCNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (w_expire) begin
                    frame_err = 1'b1;
                    w_state   = IDLE;
                end else if (!rx_empty) begin
                    rd_uart = 1'b1;
                    w_wdata = {r_wdata[23:0], r_data};
                    if (r_cnt == BCNT_W'(DATA_BYTES - 1)) begin
                        w_cnt   = '0;
                        w_state = BUS;
                    end else begin
                        w_cnt = r_cnt + BCNT_W'(1);
                    end
                end
            end
            BUS: begin
                bus_cs    = 1'b1;
                bus_write = r_is_wr;
                bus_read  = !r_is_wr;
                if (r_is_wr) begin
                    w_resp     = {RSP_ACK, 24'h0};
                    w_resp_cnt = BCNT_W'(1);
                end else begin
                    w_resp     = bus_rd_data;
                    w_resp_cnt = BCNT_W'(4);
                end
                w_state = RESP;
            end
            RESP: begin
                // Response drains MSB-first; a full tx FIFO just stalls it
                if (!tx_full) begin
                    wr_uart    = 1'b1;
                    w_resp     = {r_resp[23:0], 8'h00};
                    w_resp_cnt = r_resp_cnt - BCNT_W'(1);
                    if (r_resp_cnt == BCNT_W'(1)) w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
- Command interpreter that turns a byte stream from the UART core's rx FIFO into MMIO bus transactions; it acts as the initiator on the slot bus that UART-style slots respond to.
- Read data and write acknowledgements go back to the host through the UART core's tx FIFO.
- Sits between one uart core (FIFO side) and the MMIO controller's master port, giving a host PC debug/bring-up access to every slot register.

Parameters:
ADDR_W, 21, MMIO word address width driven on bus_addr (3 address bytes received; upper bits discarded)
TIMEOUT_CYC, 100000, idle cycles allowed between bytes of one frame; 0 disables the timeout

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_empty  input  1  uart rx FIFO empty
r_data  input  8  uart rx FIFO head byte (first-word fall-through)
rd_uart  output  1  pop rx FIFO head
tx_full  input  1  uart tx FIFO full
w_data  output  8  byte to push into tx FIFO
wr_uart  output  1  push w_data into tx FIFO
bus_cs  output  1  MMIO transaction strobe, one cycle
bus_read  output  1  read qualifier
bus_write  output  1  write qualifier
bus_addr  output  ADDR_W  MMIO word address
bus_wr_data  output  32  write data
bus_rd_data  input  32  read data, combinationally valid in the bus_cs cycle
busy  output  1  high whenever state is not IDLE
frame_err  output  1  one-cycle pulse on bad opcode or timeout

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high. On reset all outputs are 0, state is IDLE, and address, data and response registers are 0.
- Frame formats (multi-byte fields MSB first):
  - Write: 0x57 ('W'), A2 A1 A0, D3 D2 D1 D0.
  - Read: 0x52 ('R'), A2 A1 A0.
  - bus_addr = {A2,A1,A0}[ADDR_W-1:0].
- Byte accept rule: rd_uart = !rx_empty while in OPC, ADDR or DATA. The byte is taken from r_data in the same cycle. At most one byte is accepted per cycle.
- States:
  - IDLE: if !rx_empty, go to OPC. Nothing is popped in IDLE.
  - OPC:
    - 'W' or 'R': latch the opcode, clear the byte counter, go to ADDR.
    - Any other byte: pulse frame_err, load response byte 0x3F ('?'), go to RESP.
  - ADDR: shift the byte into the address register. After the 3rd byte, go to DATA for 'W' or to BUS for 'R'.
  - DATA: shift the byte into the write-data register. After the 4th byte, go to BUS.
  - BUS: exactly one cycle with bus_cs=1 and bus_write=1 for 'W' or bus_read=1 for 'R'.
    - For 'R', capture bus_rd_data into the response shift register in this cycle; response length is 4.
    - For 'W', the response is 0x4B ('K'); length is 1.
    - Then go to RESP.
  - RESP:
    - w_data = top byte of the response register; wr_uart = !tx_full.
    - On each push, shift left by 8 and decrement the count.
    - After the last push, go to IDLE.
    - While tx_full is high, wr_uart stays 0 and w_data holds.
- Timeout:
  - An inter-byte counter runs in ADDR and DATA while rx_empty=1 and clears on every accepted byte.
  - When it reaches TIMEOUT_CYC: pulse frame_err, discard the partial frame, go to IDLE (no response byte).
  - RESP is never timed out.
- Idle bus outputs: bus_cs, bus_read and bus_write are 0 outside BUS. bus_addr and bus_wr_data hold their last values.
- Reset mid-frame or mid-response: immediate return to IDLE. Partial frames are lost, and the rx FIFO contents are not flushed.
- Back-to-back frames: after RESP→IDLE, a new frame may start the next cycle. Bytes queued in the rx FIFO during BUS/RESP are preserved.
- No bus wait states: slots respond in the cs cycle.

Decomposition:
- Package uart_mmio_pkg holds:
  - state enum (IDLE, OPC, ADDR, DATA, BUS, RESP);
  - constants OPC_WR=8'h57, OPC_RD=8'h52, RSP_ACK=8'h4B, RSP_ERR=8'h3F;
  - byte-count constants ADDR_BYTES=3, DATA_BYTES=4.
- One natural sub-module: uart_mmio_timeout, the inter-byte timeout counter with clear/enable inputs and an expire output.

Test Plan:
- Write frame 57 00 01 23 DE AD BE EF, rx FIFO never empty -> one bus_cs cycle with bus_write=1, bus_addr=21'h000123, bus_wr_data=32'hDEADBEEF; then one wr_uart with w_data=8'h4B; busy returns to 0.
- Read frame 52 00 00 42 with bus model returning 32'h12345678 -> bus_cs/bus_read for one cycle, bus_addr=21'h42; tx bytes 12, 34, 56, 78 in order.
- Read with tx_full held high for 10 cycles mid-response -> no wr_uart while full; the 4 bytes are sent later, unchanged and in order, with no duplicates.
- Opcode 8'h41 -> frame_err pulses once; tx byte 3F; next frame 52 00 00 01 is handled normally.
- TIMEOUT_CYC=50, send 57 00 then stop -> frame_err pulses at the 50th empty cycle, state returns to IDLE, no bus_cs and no tx byte.
- Reset asserted during DATA and during RESP -> all outputs 0 immediately; a following full write frame completes correctly.
